// File: rtl/hull_fault_pkg.sv
// Shared definitions for the hull motor-driver fault conditioning channels.
package hull_fault_pkg;

  // Debounce FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_QUAL_ON  = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;
  localparam logic [1:0] ST_QUAL_OFF = 2'd3;

  // Qualification length used by every hull fault channel unless overridden
  localparam int unsigned HULL_DEBOUNCE_CYCLES_DEFAULT = 1000;

endpackage

// File: rtl/hull_fault_sync.sv
// Two-flop synchroniser for an asynchronous single-bit pin. Both flops
// reset to RST_VAL so a channel comes out of reset reading "no fault".
module hull_fault_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next values: shift the pin one stage per clock
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hull_fault_conditioner.sv
// Turns one raw hull driver fault pin into a debounced live level, a sticky
// fault flag for the fault PIO, a one-cycle interrupt per new fault and a
// saturating fault event counter. All outputs are registered.
module hull_fault_conditioner
  import hull_fault_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = HULL_DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W            = 10,
  parameter int unsigned EVT_W            = 8,
  parameter bit          FAULT_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fault_pin_raw,
  input  logic             clear_in,
  output logic             fault_out,
  output logic             fault_live,
  output logic             fault_irq,
  output logic [EVT_W-1:0] event_count
);

  localparam logic             PIN_INACTIVE = FAULT_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DEB_LIMIT    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [EVT_W-1:0] EVT_MAX      = '1;

  logic             pin_sync;
  logic             fault_s;
  logic             rise;
  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             fault_live_d, fault_live_q;
  logic             fault_out_d, fault_out_q;
  logic             fault_irq_d, fault_irq_q;
  logic [EVT_W-1:0] event_count_d, event_count_q;

  hull_fault_sync #(
    .RST_VAL (PIN_INACTIVE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (fault_pin_raw),
    .q       (pin_sync)
  );

  // Normalise to active-high fault
  assign fault_s = pin_sync ^ FAULT_ACTIVE_LOW;

  // Debounce FSM: a level change is accepted only after the new level has
  // been held for DEBOUNCE_CYCLES qualification cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fault_s) begin
          state_d = ST_QUAL_ON;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_QUAL_ON: begin
        if (!fault_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LIMIT) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          rise    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (!fault_s) begin
          state_d = ST_QUAL_OFF;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_QUAL_OFF: begin
        if (fault_s) begin
          // Release not qualified: the fault never went away
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LIMIT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values: live level, sticky flag (set beats clear), irq, counter
  always_comb begin
    fault_live_d  = (state_d == ST_ACTIVE) || (state_d == ST_QUAL_OFF);
    fault_irq_d   = rise;
    fault_out_d   = fault_out_q;
    event_count_d = event_count_q;
    if (rise) begin
      fault_out_d = 1'b1;
    end else if (clear_in && !fault_live_q) begin
      fault_out_d = 1'b0;
    end
    if (rise && (event_count_q != EVT_MAX)) begin
      event_count_d = event_count_q + EVT_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      fault_live_q  <= 1'b0;
      fault_out_q   <= 1'b0;
      fault_irq_q   <= 1'b0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fault_live_q  <= fault_live_d;
      fault_out_q   <= fault_out_d;
      fault_irq_q   <= fault_irq_d;
      event_count_q <= event_count_d;
    end
  end

  assign fault_out   = fault_out_q;
  assign fault_live  = fault_live_q;
  assign fault_irq   = fault_irq_q;
  assign event_count = event_count_q;

endmodule
